change_dispenser: RTL and testbench
===================================

# change_dispenser

Return-side counterpart to the vending machine's coin-input and balance logic. When the controller decides to return the balance (wait timeout or explicit return), this block takes the remaining total and emits coins greedily, largest denomination first, one coin per accepted handshake, onto `o_return_coin`. It reports completion, the number of coins issued, and any residual amount below the smallest coin.

## Interface
Parameters:
- `kNumCoins`, 3: number of coin denominations.
- `kTotalBits`, 31: width of money quantities.
- `COIN0_VALUE`, 100: smallest coin, bit 0 of `o_return_coin`.
- `COIN1_VALUE`, 500: middle coin, bit 1.
- `COIN2_VALUE`, 1000: largest coin, bit 2. Values must be strictly ascending with index.

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
  - `clk`  input  1  system clock; all state changes on the rising edge.
  - `reset`  input  1  synchronous, active-high reset.
- `i_start`  input  1  return request; sampled only in IDLE.
- `i_return_total`  input  kTotalBits  amount to return; latched when `i_start` is accepted.
- `i_coin_ready`  input  1  downstream coin hopper accepts the offered coin this cycle.
- `o_return_coin`  output  kNumCoins  one-hot coin offered; all zero when no coin is offered.
- `o_busy`  output  1  high in DISPENSE and DONE.
- `o_done`  output  1  single-cycle completion pulse.
- `o_residual`  output  kTotalBits  amount left unreturned; valid while `o_done`=1 and held until the next accepted start.
- `o_num_coins`  output  8  coins issued in the current or last transaction; saturates at 255.

## Operation
- States:
  - IDLE: `i_start`=1 latches `i_return_total` into `remaining`, clears `o_num_coins`, and moves to DISPENSE.
  - DISPENSE: offers coins until `remaining` < `COIN0_VALUE`.
  - DONE: lasts one cycle, then returns to IDLE.
- Coin selection is a combinational function of state and registered `remaining`:
  - `remaining` ≥ `COIN2_VALUE`: offer bit 2.
  - Otherwise `remaining` ≥ `COIN1_VALUE`: offer bit 1.
  - Otherwise `remaining` ≥ `COIN0_VALUE`: offer bit 0.
  - Otherwise: offer 0.
  - Outside DISPENSE, `o_return_coin` is 0.
- Transfer occurs on an edge where `o_return_coin`≠0 and `i_coin_ready`=1.
  - `remaining` is reduced by the coin's value (no underflow is possible by construction).
  - `o_num_coins` increments, saturating at 255.
- Stall: while `i_coin_ready`=0, `o_return_coin` holds the same one-hot value and `remaining` is unchanged.
- Exit: in DISPENSE, `remaining` < `COIN0_VALUE` means the next state is DONE, and `o_residual` is loaded with `remaining` on that edge.
- DONE: `o_done`=1 and `o_return_coin`=0; the next state is IDLE.
- `i_start` in DISPENSE or DONE is ignored; no queuing.
- `i_coin_ready` outside DISPENSE is ignored.

## Timing
- Reset values (edge with `reset`=1): state=IDLE, `remaining`=0, `o_return_coin`=0, `o_busy`=0, `o_done`=0, `o_residual`=0, `o_num_coins`=0.
- `reset` overrides everything, including mid-DISPENSE. Coins not yet transferred are abandoned and no `o_done` is produced.
- Start acceptance: `i_start` sampled at edge k moves the block to DISPENSE at k+1. The first coin is visible in the cycle after edge k.
- Throughput: one coin per cycle while `i_coin_ready`=1.
- Latency with ready held high and N coins:
  - N cycles of coins.
  - 1 cycle in DISPENSE with `o_return_coin`=0 (exit detection).
  - 1 cycle of DONE with `o_done`=1.
  - IDLE again on the following edge.
- `i_start` may be re-asserted in the first IDLE cycle after DONE.
- Zero or sub-coin total: DISPENSE lasts 1 cycle with no coin, then DONE with `o_residual`=total and `o_num_coins`=0.
- `o_busy` is high from the cycle after start acceptance through the DONE cycle inclusive.

## Test plan
- **Greedy, no stalls.** Total 1600, ready=1 → coins 1000, 500, 100 on consecutive cycles; then one idle DISPENSE cycle; then `o_done` with `o_residual`=0 and `o_num_coins`=3.
- **Stalls and residual.** Total 750, ready low for 3 cycles at start → 500 held stable for 3 cycles, then 500, 100, 100 transferred in sequence; `o_done` with `o_residual`=50 and `o_num_coins`=3.
- **Zero total.** Total 0 → no coin; `o_done` 2 cycles after start; `o_residual`=0.
- **Ignored start.** During a 2700 return, pulse `i_start` with total 9999 → sequence 1000, 1000, 500, 100, 100 is unaffected; `o_residual`=0.
- **Reset mid-operation.** Total 3000; assert `reset` after the first coin transfers → next cycle all outputs 0 and state IDLE; no `o_done`. A subsequent start with 100 then dispenses a single 100.
- **Back-to-back.** Total 500 then, in the first IDLE cycle after DONE, total 1000 → two clean transactions, and `o_num_coins` restarts at 0.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy coin return: latches a balance and offers the largest coin that fits,
// one coin per accepted hopper handshake, then pulses done with the leftover amount.
module change_dispenser #(
  parameter int kNumCoins   = 3,
  parameter int kTotalBits  = 31,
  parameter int COIN0_VALUE = 100,
  parameter int COIN1_VALUE = 500,
  parameter int COIN2_VALUE = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [kTotalBits-1:0] i_return_total,
  input  logic                  i_coin_ready,
  output logic [kNumCoins-1:0]  o_return_coin,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [kTotalBits-1:0] o_residual,
  output logic [7:0]            o_num_coins,
  output logic [1:0]            o_state_dbg
);

  // Coin handshake: a coin moves on a rising edge where o_return_coin is
  // non-zero and i_coin_ready is high; otherwise the offer is held unchanged.

  localparam logic [kTotalBits-1:0] kCoin0 = kTotalBits'(COIN0_VALUE);
  localparam logic [kTotalBits-1:0] kCoin1 = kTotalBits'(COIN1_VALUE);
  localparam logic [kTotalBits-1:0] kCoin2 = kTotalBits'(COIN2_VALUE);

  // Debug encoding seen on o_state_dbg: IDLE=0, DISPENSE=1, DONE=2.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DISPENSE = 2'd1,
    ST_DONE     = 2'd2
  } state_e;

  state_e                state_q;
  logic [kTotalBits-1:0] remaining_q;
  logic [kTotalBits-1:0] remaining_d;
  logic [kTotalBits-1:0] residual_q;
  logic [7:0]            num_coins_q;
  logic                  busy_q;
  logic                  done_q;
  logic [kNumCoins-1:0]  coin_sel;
  logic [kTotalBits-1:0] coin_value;

  always_comb begin
    coin_sel   = '0;
    coin_value = '0;
    if (state_q == ST_DISPENSE) begin
      if (remaining_q >= kCoin2) begin
        coin_sel[2] = 1'b1;
        coin_value  = kCoin2;
      end else if (remaining_q >= kCoin1) begin
        coin_sel[1] = 1'b1;
        coin_value  = kCoin1;
      end else if (remaining_q >= kCoin0) begin
        coin_sel[0] = 1'b1;
        coin_value  = kCoin0;
      end
    end
  end

  // The selected coin never exceeds remaining, so this cannot wrap.
  assign remaining_d = remaining_q - coin_value;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      residual_q  <= '0;
      num_coins_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            state_q     <= ST_DISPENSE;
            remaining_q <= i_return_total;
            num_coins_q <= '0;
            busy_q      <= 1'b1;
          end
        end
        ST_DISPENSE: begin
          if (remaining_q < kCoin0) begin
            state_q    <= ST_DONE;
            residual_q <= remaining_q;
            done_q     <= 1'b1;
          end else if (i_coin_ready) begin
            remaining_q <= remaining_d;
            if (num_coins_q != 8'hFF) num_coins_q <= num_coins_q + 8'd1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_return_coin = coin_sel;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_residual    = residual_q;
  assign o_num_coins   = num_coins_q;
  assign o_state_dbg   = state_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed scenarios plus random totals, checked
// against a greedy-division model of the coin sequence and residual.
module tb_change_dispenser;

  localparam int W = 3;
  localparam logic [1:0] kIdle     = 2'd0;
  localparam logic [1:0] kDispense = 2'd1;
  localparam logic [1:0] kDone     = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [30:0] i_return_total;
  logic        i_coin_ready;
  logic [2:0]  o_return_coin;
  logic        o_busy;
  logic        o_done;
  logic [30:0] o_residual;
  logic [7:0]  o_num_coins;
  logic [1:0]  o_state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  change_dispenser dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_return_total(i_return_total),
    .i_coin_ready  (i_coin_ready),
    .o_return_coin (o_return_coin),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_residual    (o_residual),
    .o_num_coins   (o_num_coins),
    .o_state_dbg   (o_state_dbg)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Driver + scoreboard for one return. Inputs change and outputs are sampled
  // on the falling edge. mode: 0 ready always high, 1 random ready,
  // 2 ready low for the first three offer cycles. poke re-pulses i_start mid-run.
  task automatic do_txn(input logic [30:0] total, input int mode, input bit poke);
    logic [W-1:0] exp_q[$];
    int n2, n1, n0, r, issued, cyc;
    bit ready;
    n2 = int'(total / 1000);
    r  = int'(total % 1000);
    n1 = r / 500;
    r  = r % 500;
    n0 = r / 100;
    r  = r % 100;
    repeat (n2) exp_q.push_back(3'b100);
    repeat (n1) exp_q.push_back(3'b010);
    repeat (n0) exp_q.push_back(3'b001);
    issued = 0;
    cyc = 0;

    i_start = 1'b1;
    i_return_total = total;
    i_coin_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    i_start = 1'b0;

    while (exp_q.size() > 0 && cyc < 2000) begin
      check("busy_dispense", {63'd0, o_busy}, 64'd1);
      check("coin", {61'd0, o_return_coin}, {61'd0, exp_q[0]});
      check("count_running", {56'd0, o_num_coins}, (issued > 255) ? 64'd255 : 64'(issued));
      case (mode)
        0:       ready = 1'b1;
        1:       ready = ($urandom_range(0, 3) != 0);
        default: ready = (cyc >= 3);
      endcase
      i_coin_ready = ready;
      if (poke && cyc == 1) begin
        i_start = 1'b1;
        i_return_total = 31'd9999;
      end else begin
        i_start = 1'b0;
      end
      @(negedge clk);
      if (ready) begin
        void'(exp_q.pop_front());
        issued++;
      end
      cyc++;
    end
    if (cyc >= 2000) check("dispense_timeout", 64'(exp_q.size()), 64'd0);

    // exit-detection cycle: still dispensing, nothing offered
    i_start = 1'b0;
    check("exit_coin", {61'd0, o_return_coin}, 64'd0);
    check("exit_done", {63'd0, o_done}, 64'd0);
    check("exit_state", {62'd0, o_state_dbg}, {62'd0, kDispense});
    i_coin_ready = 1'($urandom_range(0, 1));
    @(negedge clk);

    check("done_pulse", {63'd0, o_done}, 64'd1);
    check("done_residual", {33'd0, o_residual}, 64'(r));
    check("done_count", {56'd0, o_num_coins}, (issued > 255) ? 64'd255 : 64'(issued));
    check("done_coin", {61'd0, o_return_coin}, 64'd0);
    check("done_busy", {63'd0, o_busy}, 64'd1);
    check("done_state", {62'd0, o_state_dbg}, {62'd0, kDone});
    @(negedge clk);

    check("idle_done", {63'd0, o_done}, 64'd0);
    check("idle_busy", {63'd0, o_busy}, 64'd0);
    check("idle_state", {62'd0, o_state_dbg}, {62'd0, kIdle});
    check("idle_residual_held", {33'd0, o_residual}, 64'(r));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_coin"}, {61'd0, o_return_coin}, 64'd0);
    check({tag, "_busy"}, {63'd0, o_busy}, 64'd0);
    check({tag, "_done"}, {63'd0, o_done}, 64'd0);
    check({tag, "_residual"}, {33'd0, o_residual}, 64'd0);
    check({tag, "_count"}, {56'd0, o_num_coins}, 64'd0);
    check({tag, "_state"}, {62'd0, o_state_dbg}, {62'd0, kIdle});
  endtask

  initial begin
    reset = 1'b1;
    i_start = 1'b0;
    i_return_total = '0;
    i_coin_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);

    // greedy without stalls, stalls with residual, zero total, ignored start
    do_txn(31'd1600, 0, 1'b0);
    do_txn(31'd750, 2, 1'b0);
    do_txn(31'd0, 0, 1'b0);
    do_txn(31'd2700, 0, 1'b1);
    do_txn(31'd99, 1, 1'b0);

    // reset after the first coin of 3000 transfers
    i_start = 1'b1;
    i_return_total = 31'd3000;
    i_coin_ready = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("rst_first_coin", {61'd0, o_return_coin}, 64'd4);
    @(negedge clk);
    check("rst_after_xfer_count", {56'd0, o_num_coins}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_all_zero("midreset");
    repeat (3) begin
      @(negedge clk);
      check("midreset_no_done", {63'd0, o_done}, 64'd0);
    end
    do_txn(31'd100, 0, 1'b0);

    // back-to-back: second start in first IDLE cycle after DONE
    do_txn(31'd500, 0, 1'b0);
    do_txn(31'd1000, 0, 1'b0);

    // coin counter saturation: 300 coins of the largest value
    do_txn(31'd300000, 0, 1'b0);

    // randomized totals and ready patterns
    for (int t = 0; t < 25; t++) begin
      do_txn(31'($urandom_range(0, 6000)), 1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
